// File: rtl/dff_write_arbiter_pkg.sv
// Shared definitions for the round-robin write arbiter: FSM encoding and default sizes.
package dff_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

endpackage

// File: rtl/dff_reg_en.sv
// W-bit bank of enabled D flip-flops with async active-low clear; q_l is the complement of q.
module dff_reg_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] q_l
);

    for (genvar b = 0; b < W; b++) begin : g_bit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  q[b] <= 1'b0;
            else if (en) q[b] <= d[b];
        end
    end

    // Derived rather than stored so q_l can never disagree with q, even during reset.
    assign q_l = ~q;

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter granting N requesters one at a time write access to a shared W-bit register.
module dff_write_arbiter
    import dff_write_arbiter_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                CLK,
    input  logic                RST_L,
    input  logic [N-1:0]        REQ,
    input  logic [N-1:0][W-1:0] WDATA,
    output logic [N-1:0]        GNT,
    output logic [N-1:0]        ACK,
    output logic                BUSY,
    output logic [W-1:0]        Q,
    output logic [W-1:0]        Q_L
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_e        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cur;
    logic [PW-1:0] win;
    logic [N-1:0]  win_oh;

    // Walk from lowest to highest priority so the nearest requester after ptr is written last.
    always_comb begin
        win    = ptr;
        win_oh = '0;
        for (int k = N; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (REQ[idx]) win = PW'(idx);
        end
        win_oh[win] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state <= ST_IDLE;
            GNT   <= '0;
            ACK   <= '0;
            BUSY  <= 1'b0;
            ptr   <= PW'(N - 1);
            cur   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|REQ) begin
                        GNT   <= win_oh;
                        cur   <= win;
                        BUSY  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ACK   <= GNT;
                    GNT   <= '0;
                    ptr   <= cur;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    ACK   <= '0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    GNT   <= '0;
                    ACK   <= '0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Data is captured from the granted slice during LOAD; grant cannot be revoked by REQ.
    dff_reg_en #(.W(W)) u_reg (
        .clk   (CLK),
        .rst_n (RST_L),
        .en    (state == ST_LOAD),
        .d     (WDATA[cur]),
        .q     (Q),
        .q_l   (Q_L)
    );

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Randomized and directed bench for dff_write_arbiter against a transaction-level round-robin model.
module tb_dff_write_arbiter;
    import dff_write_arbiter_pkg::*;

    localparam int N = DEF_N;
    localparam int W = DEF_W;

    logic                clk;
    logic                rst_l;
    logic [N-1:0]        req;
    logic [N-1:0][W-1:0] wdata;
    logic [N-1:0]        gnt;
    logic [N-1:0]        ack;
    logic                busy;
    logic [W-1:0]        q;
    logic [W-1:0]        q_l;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_ptr  = N - 1;
    logic [W-1:0] m_q = '0;

    dff_write_arbiter #(.N(N), .W(W)) dut (
        .CLK(clk), .RST_L(rst_l), .REQ(req), .WDATA(wdata),
        .GNT(gnt), .ACK(ack), .BUSY(busy), .Q(q), .Q_L(q_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference rule: first requester found searching p+1, p+2, ... modulo N.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Drives one write transaction starting in IDLE at a falling edge and records what is seen.
    task automatic run_xact(input logic [N-1:0] r, input logic [N-1:0] r_load,
                            output logic [N-1:0] g1, output logic b1, output logic [W-1:0] q1,
                            output logic [N-1:0] a2, output logic [N-1:0] g2,
                            output logic [W-1:0] q2, output logic [W-1:0] ql2,
                            output logic [N-1:0] a3, output logic b3, output int t2);
        req = r;
        @(negedge clk);
        g1 = gnt; b1 = busy; q1 = q; req = r_load;
        @(negedge clk);
        a2 = ack; g2 = gnt; q2 = q; ql2 = q_l; t2 = cyc; req = r_load & ~ack;
        @(negedge clk);
        a3 = ack; b3 = busy;
    endtask

    task automatic test_reset();
        rst_l = 1'b0; req = '0; wdata = '0;
        #1;
        checks++;
        if ({gnt, ack, busy, q, q_l} !== {{N{1'b0}}, {N{1'b0}}, 1'b0, {W{1'b0}}, {W{1'b1}}}) begin
            errors++; $display("FAIL reset_async gnt=%b ack=%b busy=%b q=%h ql=%h", gnt, ack, busy, q, q_l);
        end
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({gnt, ack, busy, q, q_l} !== {{N{1'b0}}, {N{1'b0}}, 1'b0, 8'h00, 8'hFF}) begin
                errors++; $display("FAIL idle_%0d gnt=%b ack=%b busy=%b q=%h ql=%h exp 0/0/0/00/ff", i, gnt, ack, busy, q, q_l);
            end
        end
        m_ptr = N - 1; m_q = '0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] pend, g1, a2, g2, a3;
        logic b1, b3;
        logic [W-1:0] q1, q2, ql2;
        int t2, t_prev;
        pend = 4'b1111; t_prev = -1;
        for (int i = 0; i < N; i++) wdata[i] = 8'h10 + 8'(i);
        for (int i = 0; i < N; i++) begin
            run_xact(pend, pend, g1, b1, q1, a2, g2, q2, ql2, a3, b3, t2);
            checks++;
            if (a2 !== 4'(1 << i) || q2 !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL rr_order_%0d ack=%b q=%h exp ack=%b q=%h", i, a2, q2, 4'(1 << i), 8'h10 + 8'(i));
            end
            if (t_prev >= 0) begin
                checks++;
                if (t2 - t_prev !== 3) begin
                    errors++; $display("FAIL rr_spacing_%0d got %0d exp 3", i, t2 - t_prev);
                end
            end
            t_prev = t2;
            pend = pend & ~a2;
        end
        m_ptr = N - 1; m_q = 8'h13;
    endtask

    task automatic test_fairness();
        logic [N-1:0] g1, a2, g2, a3;
        logic b1, b3;
        logic [W-1:0] q1, q2, ql2;
        int t2;
        wdata[0] = 8'h60; wdata[3] = 8'h63;
        run_xact(4'b1001, 4'b1001, g1, b1, q1, a2, g2, q2, ql2, a3, b3, t2);
        checks++;
        if (a2 !== 4'b0001 || q2 !== 8'h60) begin
            errors++; $display("FAIL wrap_to_0 ack=%b q=%h exp ack=0001 q=60", a2, q2);
        end
        run_xact(4'b1000, 4'b1000, g1, b1, q1, a2, g2, q2, ql2, a3, b3, t2);
        checks++;
        if (g1 !== 4'b1000 || a2 !== 4'b1000 || q2 !== 8'h63) begin
            errors++; $display("FAIL held_3_wins gnt=%b ack=%b q=%h exp 1000/1000/63", g1, a2, q2);
        end
        m_ptr = 3; m_q = 8'h63;
    endtask

    task automatic test_single();
        logic [N-1:0] g1, a2, g2, a3;
        logic b1, b3;
        logic [W-1:0] q1, q2, ql2;
        int t2;
        wdata[2] = 8'hA5;
        run_xact(4'b0100, 4'b0100, g1, b1, q1, a2, g2, q2, ql2, a3, b3, t2);
        checks++;
        if (g1 !== 4'b0100 || b1 !== 1'b1 || q1 !== m_q) begin
            errors++; $display("FAIL single_grant gnt=%b busy=%b q=%h exp 0100/1/%h", g1, b1, q1, m_q);
        end
        checks++;
        if (a2 !== 4'b0100 || g2 !== 4'b0000 || q2 !== 8'hA5 || ql2 !== 8'h5A) begin
            errors++; $display("FAIL single_load ack=%b gnt=%b q=%h ql=%h exp 0100/0000/a5/5a", a2, g2, q2, ql2);
        end
        checks++;
        if (a3 !== 4'b0000 || b3 !== 1'b0) begin
            errors++; $display("FAIL single_ack_pulse ack=%b busy=%b exp 0000/0", a3, b3);
        end
        m_ptr = 2; m_q = 8'hA5;
    endtask

    task automatic test_no_revoke();
        logic [N-1:0] g1, a2, g2, a3;
        logic b1, b3;
        logic [W-1:0] q1, q2, ql2;
        int t2;
        wdata[1] = 8'h3C;
        run_xact(4'b0010, 4'b0000, g1, b1, q1, a2, g2, q2, ql2, a3, b3, t2);
        checks++;
        if (a2 !== 4'b0010 || q2 !== 8'h3C || ql2 !== 8'hC3) begin
            errors++; $display("FAIL no_revoke ack=%b q=%h ql=%h exp 0010/3c/c3", a2, q2, ql2);
        end
        m_ptr = 1; m_q = 8'h3C;
    endtask

    task automatic test_reset_mid();
        // Clear Q first so the abort is checked against a known zero register.
        rst_l = 1'b0; #1; rst_l = 1'b1;
        @(negedge clk);
        wdata[0] = 8'hFF; req = 4'b0001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL mid_pre_grant gnt=%b exp 0001", gnt);
        end
        rst_l = 1'b0; req = '0;
        #1;
        checks++;
        if (gnt !== '0 || ack !== '0 || busy !== 1'b0 || q !== 8'h00 || q_l !== 8'hFF) begin
            errors++; $display("FAIL mid_abort gnt=%b ack=%b busy=%b q=%h exp 0/0/0/00", gnt, ack, busy, q);
        end
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ack !== '0 || q !== 8'h00 || busy !== 1'b0) begin
                errors++; $display("FAIL mid_after_%0d ack=%b q=%h busy=%b exp 0/00/0", i, ack, q, busy);
            end
        end
        m_ptr = N - 1; m_q = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] r, rl, g1, a2, g2, a3, exp_oh;
        logic b1, b3;
        logic [W-1:0] q1, q2, ql2;
        int t2, w;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) wdata[i] = 8'($urandom);
            r  = 4'($urandom_range(1, 15));
            rl = 4'($urandom);
            w  = pick(r, m_ptr);
            exp_oh = 4'(1 << w);
            run_xact(r, rl, g1, b1, q1, a2, g2, q2, ql2, a3, b3, t2);
            checks++;
            if (g1 !== exp_oh || b1 !== 1'b1 || q1 !== m_q) begin
                errors++; $display("FAIL rand_grant_%0d gnt=%b busy=%b q=%h exp %b/1/%h", it, g1, b1, q1, exp_oh, m_q);
            end
            checks++;
            if (a2 !== exp_oh || g2 !== '0 || q2 !== wdata[w] || ql2 !== ~wdata[w]) begin
                errors++; $display("FAIL rand_write_%0d ack=%b gnt=%b q=%h ql=%h exp %b/0000/%h/%h", it, a2, g2, q2, ql2, exp_oh, wdata[w], ~wdata[w]);
            end
            checks++;
            if (a3 !== '0 || b3 !== 1'b0) begin
                errors++; $display("FAIL rand_done_%0d ack=%b busy=%b exp 0000/0", it, a3, b3);
            end
            m_ptr = w; m_q = wdata[w];
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fairness();
        test_single();
        test_no_revoke();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_write_arbiter.md
Name: dff_write_arbiter

Overview:
- Round-robin arbiter that shares one W-bit register, built from D flip-flops, between N requesters.
- Each requester raises REQ and presents its data. The arbiter grants one requester at a time, loads that requester's data into the shared register, and returns a one-cycle ACK.
- It sits between requester logic and the shared storage register. It drives Q and Q_L, where Q_L is the bitwise complement of Q.

Parameters:
N, 4, number of requesters (2..8)
W, 8, width of shared register in bits

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST_L  input  1  asynchronous active-low reset
REQ  input  N  per-requester write request, level; held until matching ACK
WDATA  input  N*W  concatenated write data; requester i at bits [i*W+W-1 : i*W]
GNT  output  N  one-hot grant, registered
ACK  output  N  one-hot write-complete pulse, one cycle, registered
BUSY  output  1  high whenever FSM is not in IDLE
Q  output  W  shared register contents
Q_L  output  W  bitwise complement of Q

Behaviour:
- Reset (RST_L=0, takes effect immediately, independent of CLK):
  - state=IDLE; GNT=0; ACK=0; BUSY=0; Q=0; Q_L={W{1}}.
  - last-winner pointer PTR=N-1, so requester 0 has top priority after reset.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Else, winner = first set bit of REQ, searching PTR+1, PTR+2, ... mod N.
  - Next edge: GNT<=onehot(winner), state<=LOAD.
- LOAD:
  - Next edge: Q<=WDATA slice of the granted requester, sampled in the LOAD cycle; Q_L<=~that data.
  - Same edge: ACK<=GNT, GNT<=0, PTR<=winner index, state<=DONE.
- DONE:
  - ACK is high for exactly this cycle.
  - Next edge: ACK<=0, state<=IDLE.
  - REQ is not sampled for arbitration in DONE.
- Latency and throughput:
  - REQ seen in IDLE at edge k gives GNT high from k+1, with Q updated and ACK high from k+2.
  - ACK falls at k+3.
  - Maximum throughput is one write per 3 cycles.
- Requester rules:
  - A requester deasserts REQ in the cycle after it sees ACK.
  - If REQ is still high when the FSM re-enters IDLE, it is treated as a new request. Round-robin order still applies, so other pending requesters win first.
- Deassertion rules:
  - If the granted requester drops REQ during LOAD, the write still completes and ACK is still issued. Grant is not revocable.
  - Changes to REQ of non-granted requesters during LOAD or DONE do not affect the current transaction.
- Register hold: Q and Q_L change only on the LOAD->DONE edge or at reset; otherwise they hold.
- Pointer wrap-around: after winner N-1, the search starts at 0.
- Simultaneous requests: with all REQ bits high, grants rotate 0,1,...,N-1,0,...
- Reset mid-operation:
  - Asserting RST_L=0 in LOAD or DONE aborts the transaction immediately.
  - Q returns to 0 and no ACK is issued.
- Invariants:
  - GNT and ACK are each one-hot or zero and are never high in the same cycle.
  - Q_L == ~Q at all times.

Decomposition:
- Shared header, included by RTL and bench:
  - state encodings ST_IDLE=2'd0, ST_LOAD=2'd1, ST_DONE=2'd2.
  - default N and W values.
- One sub-module, dff_reg_en:
  - W-bit register of D flip-flops with enable, asynchronous active-low reset to 0, and outputs Q and Q_L.
  - The arbiter instantiates it once, with enable = (state==LOAD).
- Winner search, the round-robin priority mask, stays in the arbiter as combinational logic.

Test Plan:
1. Reset then idle: RST_L=0 for 2 cycles, then 1, REQ=0 for 5 cycles -> GNT=0, ACK=0, BUSY=0, Q=8'h00, Q_L=8'hFF throughout.
2. Single write: REQ=4'b0100, WDATA slice 2=8'hA5 -> GNT=4'b0100 one cycle after REQ is sampled; next cycle Q=8'hA5, Q_L=8'h5A, ACK=4'b0100 for exactly one cycle.
3. Round robin: REQ=4'b1111 held, each requester dropping its bit after its ACK, slice i data=8'h10+i -> ACK order 0,1,2,3; Q sequence 8'h10, 8'h11, 8'h12, 8'h13; 3 cycles between consecutive ACKs.
4. Fairness and wrap: after requester 3 wins, REQ=4'b1001 -> requester 0 wins next; then requester 3 keeps REQ high -> requester 3 wins next.
5. Grant not revocable: REQ=4'b0010, slice 1=8'h3C, REQ dropped during LOAD -> Q=8'h3C and ACK=4'b0010 still issued.
6. Reset mid-operation: RST_L pulsed low during LOAD with slice 0=8'hFF pending -> GNT, ACK and BUSY go to 0 immediately; Q stays 8'h00; no ACK after release.
